// File: rtl/bip_program_loader.sv
// UART program loader for the BIP CPU: assembles little-endian byte pairs into
// instruction words, writes them from address 0, then runs the CPU until it halts.
module bip_program_loader #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 11,
    parameter logic [7:0]        SYNC_BYTE   = 8'h55,
    parameter logic [DATA_W-1:0] HALT_WORD   = '0,
    parameter int                TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              finish_program,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              prog_wr,
    output logic              bip_enable,
    output logic [ADDR_W:0]   loaded_words,
    output logic              load_error
);

    // state   | meaning
    // IDLE    | waiting for the sync byte; other bytes dropped
    // LOAD_LO | waiting for the low byte of the next word
    // LOAD_HI | waiting for the high byte of the next word
    // WRITE   | one-cycle program memory write strobe
    // RUN     | CPU enabled until finish_program
    typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, WRITE, RUN} state_t;

    localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, next_state;
    logic [7:0]       lo_byte;
    logic [CNT_W-1:0] tmo_cnt;
    logic             loading;
    logic             tmo_hit;
    logic             last_word;

    assign loading   = (state == LOAD_LO) || (state == LOAD_HI);
    // an arriving byte beats expiry in the same cycle
    assign tmo_hit   = loading && !rx_done && (tmo_cnt == TMO_LAST);
    assign last_word = (prog_data == HALT_WORD) || (prog_addr == {ADDR_W{1'b1}});
    assign prog_wr   = (state == WRITE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rx_done && rx_data == SYNC_BYTE) next_state = LOAD_LO;
            LOAD_LO: if (rx_done) next_state = LOAD_HI;
                     else if (tmo_hit) next_state = IDLE;
            LOAD_HI: if (rx_done) next_state = WRITE;
                     else if (tmo_hit) next_state = IDLE;
            WRITE:   next_state = last_word ? RUN : LOAD_LO;
            RUN:     if (finish_program) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_addr    <= '0;
            prog_data    <= '0;
            bip_enable   <= 1'b0;
            loaded_words <= '0;
            load_error   <= 1'b0;
            lo_byte      <= '0;
            tmo_cnt      <= '0;
        end else begin
            // registered from RUN so the CPU starts the cycle after RUN is entered
            bip_enable <= (state == RUN) && !finish_program;
            case (state)
                IDLE: begin
                    if (rx_done && rx_data == SYNC_BYTE) begin
                        prog_addr  <= '0;
                        load_error <= 1'b0;
                        tmo_cnt    <= '0;
                    end
                end
                LOAD_LO, LOAD_HI: begin
                    if (rx_done) begin
                        tmo_cnt <= '0;
                        if (state == LOAD_LO) lo_byte <= rx_data;
                        else                  prog_data <= DATA_W'({rx_data, lo_byte});
                    end else if (tmo_hit) begin
                        load_error <= 1'b1;
                        tmo_cnt    <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    loaded_words <= {1'b0, prog_addr} + 1'b1;
                    tmo_cnt      <= '0;
                    if (!last_word) prog_addr <= prog_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_program_loader.sv
// Scoreboard bench for bip_program_loader: a full-size instance with a short
// timeout and a tiny-memory instance for the memory-full case.
module tb_bip_program_loader;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [7:0]  rx_data_a = '0, rx_data_b = '0;
    logic        rx_done_a = 1'b0, rx_done_b = 1'b0;
    logic        fin_a = 1'b0, fin_b = 1'b0;

    logic [10:0] prog_addr_a;
    logic [15:0] prog_data_a;
    logic        prog_wr_a, bip_enable_a, load_error_a;
    logic [11:0] loaded_words_a;

    logic [2:0]  prog_addr_b;
    logic [15:0] prog_data_b;
    logic        prog_wr_b, bip_enable_b, load_error_b;
    logic [3:0]  loaded_words_b;

    int vectors = 0;
    int miscompares = 0;
    wr_t q_a[$];
    wr_t q_b[$];

    always #5 clk = ~clk;

    bip_program_loader #(.ADDR_W(11), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data_a), .rx_done(rx_done_a),
        .finish_program(fin_a), .prog_addr(prog_addr_a), .prog_data(prog_data_a),
        .prog_wr(prog_wr_a), .bip_enable(bip_enable_a),
        .loaded_words(loaded_words_a), .load_error(load_error_a));

    bip_program_loader #(.ADDR_W(3), .TIMEOUT_CYC(16)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data_b), .rx_done(rx_done_b),
        .finish_program(fin_b), .prog_addr(prog_addr_b), .prog_data(prog_data_b),
        .prog_wr(prog_wr_b), .bip_enable(bip_enable_b),
        .loaded_words(loaded_words_b), .load_error(load_error_b));

    // write monitors: every strobe must match the next expected write
    always @(negedge clk) begin
        wr_t e;
        if (prog_wr_a === 1'b1) begin
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL wr_a unexpected: addr=%h data=%h", prog_addr_a, prog_data_a);
            end else begin
                e = q_a.pop_front();
                if (prog_addr_a !== e.addr || prog_data_a !== e.data) begin
                    miscompares++;
                    $display("FAIL wr_a: got addr=%h data=%h want addr=%h data=%h",
                             prog_addr_a, prog_data_a, e.addr, e.data);
                end
            end
        end
        if (prog_wr_b === 1'b1) begin
            vectors++;
            if (q_b.size() == 0) begin
                miscompares++;
                $display("FAIL wr_b unexpected: addr=%h data=%h", prog_addr_b, prog_data_b);
            end else begin
                e = q_b.pop_front();
                if (11'(prog_addr_b) !== e.addr || prog_data_b !== e.data) begin
                    miscompares++;
                    $display("FAIL wr_b: got addr=%h data=%h want addr=%h data=%h",
                             prog_addr_b, prog_data_b, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input bit sel, input logic [7:0] b);
        @(posedge clk); #1;
        if (sel) begin rx_data_b = b; rx_done_b = 1'b1; end
        else     begin rx_data_a = b; rx_done_a = 1'b1; end
        @(posedge clk); #1;
        rx_done_a = 1'b0;
        rx_done_b = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [15:0] w, input logic [10:0] addr);
        wr_t e;
        e.addr = addr;
        e.data = w;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        send_byte(sel, w[7:0]);
        send_byte(sel, w[15:8]);
    endtask

    task automatic pulse_finish_a();
        @(posedge clk); #1;
        fin_a = 1'b1;
        @(posedge clk); #1;
        fin_a = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({prog_addr_a, prog_data_a, prog_wr_a, bip_enable_a, loaded_words_a, load_error_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_a: addr=%h data=%h wr=%b en=%b words=%0d err=%b",
                     prog_addr_a, prog_data_a, prog_wr_a, bip_enable_a, loaded_words_a, load_error_a);
        end
        vectors++;
        if ({prog_addr_b, prog_data_b, prog_wr_b, bip_enable_b, loaded_words_b, load_error_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: addr=%h data=%h wr=%b en=%b words=%0d err=%b",
                     prog_addr_b, prog_data_b, prog_wr_b, bip_enable_b, loaded_words_b, load_error_b);
        end
        #10 reset = 1'b1;
        idle(2);
    endtask

    task automatic test_normal_load();
        send_byte(0, 8'h55);
        send_word(0, 16'h1234, 11'd0);
        send_word(0, 16'h5678, 11'd1);
        send_word(0, 16'h0000, 11'd2);
        // one edge after the HLT high byte: writing, CPU not yet enabled
        vectors++;
        if (prog_wr_a !== 1'b1 || bip_enable_a !== 1'b0) begin
            miscompares++;
            $display("FAIL hlt_latency_wr: wr=%b en=%b want wr=1 en=0", prog_wr_a, bip_enable_a);
        end
        idle(1);
        vectors++;
        if (bip_enable_a !== 1'b0) begin
            miscompares++;
            $display("FAIL hlt_latency_2: en=%b want 0", bip_enable_a);
        end
        idle(1);
        vectors++;
        if (bip_enable_a !== 1'b1 || loaded_words_a !== 12'd3 || prog_addr_a !== 11'd2) begin
            miscompares++;
            $display("FAIL normal_done: en=%b words=%0d addr=%0d want en=1 words=3 addr=2",
                     bip_enable_a, loaded_words_a, prog_addr_a);
        end
    endtask

    task automatic test_run_finish();
        send_byte(0, 8'h55);
        send_byte(0, 8'h34);
        send_byte(0, 8'h12);
        idle(2);
        vectors++;
        if (bip_enable_a !== 1'b1 || loaded_words_a !== 12'd3) begin
            miscompares++;
            $display("FAIL run_ignores_rx: en=%b words=%0d want en=1 words=3", bip_enable_a, loaded_words_a);
        end
        pulse_finish_a();
        vectors++;
        if (bip_enable_a !== 1'b0) begin
            miscompares++;
            $display("FAIL finish: en=%b want 0", bip_enable_a);
        end
        send_byte(0, 8'h55);
        pulse_finish_a();
        send_word(0, 16'h0001, 11'd0);
        send_word(0, 16'h0000, 11'd1);
        idle(3);
        vectors++;
        if (loaded_words_a !== 12'd2 || bip_enable_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reload: words=%0d en=%b want words=2 en=1", loaded_words_a, bip_enable_a);
        end
        pulse_finish_a();
    endtask

    task automatic test_noise();
        send_byte(0, 8'hAA);
        send_byte(0, 8'h00);
        send_byte(0, 8'h55);
        send_word(0, 16'h0000, 11'd0);
        idle(3);
        vectors++;
        if (loaded_words_a !== 12'd1 || bip_enable_a !== 1'b1 || load_error_a !== 1'b0) begin
            miscompares++;
            $display("FAIL noise: words=%0d en=%b err=%b want words=1 en=1 err=0",
                     loaded_words_a, bip_enable_a, load_error_a);
        end
        pulse_finish_a();
    endtask

    task automatic test_reset_midstream();
        send_byte(0, 8'h55);
        send_word(0, 16'h1234, 11'd0);
        send_byte(0, 8'h78);
        #3 reset = 1'b0;
        #1;
        vectors++;
        if ({prog_addr_a, prog_data_a, prog_wr_a, bip_enable_a, loaded_words_a, load_error_a} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: addr=%h data=%h words=%0d want all 0",
                     prog_addr_a, prog_data_a, loaded_words_a);
        end
        #2 reset = 1'b1;
        send_byte(0, 8'h12);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        idle(4);
        vectors++;
        if (loaded_words_a !== 12'd0 || bip_enable_a !== 1'b0 || prog_addr_a !== 11'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: words=%0d en=%b addr=%0d want 0 0 0",
                     loaded_words_a, bip_enable_a, prog_addr_a);
        end
    endtask

    task automatic test_timeout();
        send_byte(0, 8'h55);
        send_word(0, 16'h1234, 11'd0);
        send_byte(0, 8'h78);
        idle(15);
        vectors++;
        if (load_error_a !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: err=%b want 0 after 15 idle cycles", load_error_a);
        end
        idle(1);
        vectors++;
        if (load_error_a !== 1'b1 || bip_enable_a !== 1'b0 || loaded_words_a !== 12'd1) begin
            miscompares++;
            $display("FAIL timeout: err=%b en=%b words=%0d want err=1 en=0 words=1",
                     load_error_a, bip_enable_a, loaded_words_a);
        end
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        idle(4);
        vectors++;
        if (bip_enable_a !== 1'b0 || loaded_words_a !== 12'd1 || load_error_a !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_idle: en=%b words=%0d err=%b want 0 1 1",
                     bip_enable_a, loaded_words_a, load_error_a);
        end
        // byte arriving on the expiry cycle is accepted
        send_byte(0, 8'h55);
        send_byte(0, 8'h34);
        begin
            wr_t e;
            e.addr = 11'd0;
            e.data = 16'h1234;
            q_a.push_back(e);
        end
        repeat (14) @(posedge clk);
        send_byte(0, 8'h12);
        send_word(0, 16'h0000, 11'd1);
        idle(3);
        vectors++;
        if (load_error_a !== 1'b0 || loaded_words_a !== 12'd2 || bip_enable_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_beats_timeout: err=%b words=%0d en=%b want err=0 words=2 en=1",
                     load_error_a, loaded_words_a, bip_enable_a);
        end
        pulse_finish_a();
    endtask

    task automatic test_full_memory();
        logic [15:0] w;
        send_byte(1, 8'h55);
        for (int i = 0; i < 8; i++) begin
            w = (i == 0) ? 16'h5555 : {8'(i), 8'(8'hA0 + i)};
            send_word(1, w, 11'(i));
        end
        idle(3);
        vectors++;
        if (loaded_words_b !== 4'd8 || bip_enable_b !== 1'b1 || prog_addr_b !== 3'd7) begin
            miscompares++;
            $display("FAIL full_mem: words=%0d en=%b addr=%0d want words=8 en=1 addr=7",
                     loaded_words_b, bip_enable_b, prog_addr_b);
        end
        send_byte(1, 8'h34);
        send_byte(1, 8'h12);
        idle(3);
        vectors++;
        if (bip_enable_b !== 1'b1 || prog_addr_b !== 3'd7) begin
            miscompares++;
            $display("FAIL full_mem_hold: en=%b addr=%0d want en=1 addr=7", bip_enable_b, prog_addr_b);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_run_finish();
        test_noise();
        test_reset_midstream();
        test_timeout();
        test_full_memory();
        idle(2);
        vectors++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: pending a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
